ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the single-cycle core top. It supplies `inst`/`PC` to that stage.
- Owns the architectural fetch PC and issues one read per instruction on a valid/ready instruction-memory port (AXI-lite AR/R subset).
- Presents each fetched instruction to the core through a valid/ready handshake.
- Accepts PC redirects from the core for branches and jumps.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = in reset); deassert synchronous to clk.
- mem_araddr  output  ADDR_W  read address.
- mem_arvalid  output  1  read request valid.
- mem_arready  input  1  memory accepts request.
- mem_rdata  input  DATA_W  read data.
- mem_rresp  input  2  response code; 2'b00 = OKAY, any other value = error.
- mem_rvalid  input  1  read response valid.
- mem_rready  output  1  fetch unit accepts response.
- out_valid  output  1  out_inst/out_pc valid to core.
- out_ready  input  1  core consumes instruction.
- out_inst  output  DATA_W  fetched instruction.
- out_pc  output  ADDR_W  address of out_inst.
- out_err  output  1  out_inst came from an error response.
- redirect_valid  input  1  core requests new fetch PC.
- redirect_pc  input  ADDR_W  new PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset values (rst=0):
  - state=REQ; pc_q=RESET_PC.
  - mem_arvalid=0, mem_rready=0, out_valid=0.
  - out_inst=32'h0000_0013 (NOP), out_pc=RESET_PC, out_err=0.
  - discard=0.
- mem_arvalid first rises in the first cycle after rst deasserts.
- State REQ:
  - mem_arvalid=1, mem_araddr=pc_q.
  - Address and valid are held stable until mem_arready=1.
  - On handshake go to WAIT.
- State WAIT:
  - mem_rready=1.
  - On mem_rvalid with discard=0:
    - out_inst = rdata if rresp==OKAY, else 32'h0010_0073 (EBREAK).
    - out_err = (rresp!=OKAY); out_pc = pc_q.
    - Go to HOLD.
  - On mem_rvalid with discard=1: drop the beat, clear discard, go to REQ.
  - mem_rvalid seen in REQ or HOLD is ignored; rready=0 there.
- State HOLD:
  - out_valid=1; outputs stay stable until out_ready=1.
  - On out_ready: pc_q <= pc_q + 4, modulo 2^ADDR_W (32'hFFFF_FFFC wraps to 0). Go to REQ.
- Latency and throughput:
  - With zero-wait memory (arready=1, rvalid the cycle after the AR handshake) and out_ready=1: AR handshake in cycle N, R beat in cycle N+1, out_valid high in cycle N+2.
  - Throughput is one instruction per 3 cycles. No outstanding reads beyond one.
- Redirect handling (redirect_valid=1):
  - In HOLD:
    - Takes priority over pc+4: pc_q <= {redirect_pc[ADDR_W-1:2],2'b00}.
    - Go to REQ; out_valid falls the next cycle.
    - If out_ready is also 1 that cycle, the held instruction counts as consumed.
  - In REQ before the handshake:
    - The address must not change.
    - Record pending_pc and set discard=1.
    - Complete the handshake, go to WAIT, drop that response, then fetch pending_pc.
  - In REQ with arready=1 the same cycle, or in WAIT: set discard=1 and record pending_pc.
  - When the discarded beat arrives, pc_q <= pending_pc.
  - Multiple redirects before the drop: the last one wins.
- Reset mid-operation:
  - Immediate return to reset values. Any in-flight response is lost.
  - The memory model must tolerate the abandoned request.

Decomposition:
- Shared package `ifu_pkg`:
  - state enum {REQ, WAIT, HOLD}.
  - RRESP_OKAY=2'b00.
  - INST_NOP=32'h0000_0013.
  - INST_EBREAK=32'h0010_0073.
  - Default RESET_PC.
- Single module; no sub-module needed. The existing register primitive is not reused because its reset style differs.

Test Plan:
- Reset release, zero-wait memory, out_ready=1 -> araddr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. Each out_valid comes 2 cycles after its AR handshake, with out_pc matching its address.
- out_ready=0 for 5 cycles in HOLD -> out_inst/out_pc stable, no new arvalid; release -> next araddr = pc+4.
- rresp=2'b10 on fetch at 0x8000_0010 -> out_inst=0x0010_0073, out_err=1, out_pc=0x8000_0010.
- Redirect to 0x8000_0102 during WAIT -> the in-flight beat produces no out_valid; next araddr=0x8000_0100.
- Redirect to 0x8000_0200 in REQ with arready held low 3 cycles -> araddr stays at the old PC until handshake, the old beat is dropped, next araddr=0x8000_0200.
- Drive rst=0 while in WAIT, then release -> all outputs at reset values; the first araddr after release = 0x8000_0000.
- pc_q forced to 0xFFFF_FFFC via redirect -> next sequential araddr=0x0000_0000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Instructions substituted on reset and on error responses live here.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [1:0]  RRESP_OKAY   = 2'b00;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding AR/R read per instruction, result held for the core.
// Latency AR handshake -> out_valid is 2 cycles; out_valid holds until out_ready or a redirect.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pending_pc_q;
  logic                discard_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_inst_q;
  logic [ADDR_W-1:0]   out_pc_q;
  logic                out_err_q;

  logic [ADDR_W-1:0]   redirect_pc_d;
  logic [ADDR_W-1:0]   pc_seq_d;

  assign redirect_pc_d = redirect_pc & ~ADDR_W'(3);
  assign pc_seq_d      = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      discard_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= DATA_W'(INST_NOP);
      out_pc_q     <= RESET_PC;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (!arvalid_q) begin
            // Only the first cycle out of reset: nothing presented yet, so retarget directly.
            arvalid_q <= 1'b1;
            if (redirect_valid) pc_q <= redirect_pc_d;
          end else begin
            // Address is already on the bus and must stay put; finish it and drop the beat.
            if (redirect_valid) begin
              discard_q    <= 1'b1;
              pending_pc_q <= redirect_pc_d;
            end
            if (mem_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= WAIT;
            end
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            rready_q <= 1'b0;
            if (redirect_valid || discard_q) begin
              // A redirect arriving with the beat is the newest target and wins.
              pc_q      <= redirect_valid ? redirect_pc_d : pending_pc_q;
              discard_q <= 1'b0;
              arvalid_q <= 1'b1;
              state_q   <= REQ;
            end else begin
              out_inst_q  <= (mem_rresp == RRESP_OKAY) ? mem_rdata : DATA_W'(INST_EBREAK);
              out_err_q   <= (mem_rresp != RRESP_OKAY);
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end else if (redirect_valid) begin
            discard_q    <= 1'b1;
            pending_pc_q <= redirect_pc_d;
          end
        end

        HOLD: begin
          if (redirect_valid || out_ready) begin
            pc_q        <= redirect_valid ? redirect_pc_d : pc_seq_d;
            out_valid_q <= 1'b0;
            arvalid_q   <= 1'b1;
            state_q     <= REQ;
          end
        end

        default: begin
          state_q   <= REQ;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_araddr  = pc_q;
  assign mem_arvalid = arvalid_q;
  assign mem_rready  = rready_q;
  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign out_err     = out_err_q;

endmodule
